// File: rtl/fasm_cfg_loader.sv
// Serial config loader + inverted-input OR cell; commits INIT/INV on the parity-bit edge, no backpressure (CFG_EN gaps hold state).
// Optional readback shifter enabled by FASM_CFG_READBACK_EN.
module fasm_cfg_loader #(
   parameter int         INIT_WIDTH = 16,
   parameter logic [7:0] SYNC_WORD  = 8'hA5
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  CFG_EN,
   input  logic                  CFG_DI,
   output logic                  CFG_DONE,
   output logic                  CFG_ERR,
   output logic [INIT_WIDTH-1:0] INIT_Q,
   output logic [1:0]            INV_Q,
   input  logic                  I1,
   input  logic                  I2,
   output logic                  O
`ifdef FASM_CFG_READBACK_EN
   ,
   input  logic                  RB_EN,
   output logic                  RB_DO
`endif
);

   localparam int CNT_MAX = (INIT_WIDTH > 8) ? INIT_WIDTH : 8;
   localparam int CW      = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {HUNT, LOAD_INIT, LOAD_INV, CHECK} state_t;

   state_t                  state, state_d;
   logic [7:0]              window, window_d, window_sh;
   logic [CW-1:0]           cnt, cnt_d;
   logic [INIT_WIDTH-1:0]   sh_init, sh_init_d;
   logic [1:0]              sh_inv, sh_inv_d;
   logic                    commit, frame_bad;

   assign window_sh = (window << 1) | {7'b0, CFG_DI};

   always_comb begin
      state_d   = state;
      window_d  = window;
      cnt_d     = cnt;
      sh_init_d = sh_init;
      sh_inv_d  = sh_inv;
      commit    = 1'b0;
      frame_bad = 1'b0;
      if (CFG_EN) begin
         case (state)
            HUNT: begin
               window_d = window_sh;
               if (window_sh == SYNC_WORD) begin
                  state_d  = LOAD_INIT;
                  cnt_d    = '0;
                  window_d = '0;
               end
            end
            LOAD_INIT: begin
               sh_init_d = (sh_init << 1) | INIT_WIDTH'(CFG_DI);
               if (cnt == CW'(INIT_WIDTH - 1)) begin
                  state_d = LOAD_INV;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt + 1'b1;
               end
            end
            LOAD_INV: begin
               sh_inv_d = {sh_inv[0], CFG_DI};
               if (cnt == CW'(1)) begin
                  state_d = CHECK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt + 1'b1;
               end
            end
            CHECK: begin
               // Even parity over INIT, INV and the parity bit itself
               if (^{sh_init, sh_inv, CFG_DI}) frame_bad = 1'b1;
               else                            commit    = 1'b1;
               state_d  = HUNT;
               window_d = '0;
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= HUNT;
         window   <= '0;
         cnt      <= '0;
         sh_init  <= '0;
         sh_inv   <= '0;
         INIT_Q   <= '0;
         INV_Q    <= '0;
         CFG_DONE <= 1'b0;
         CFG_ERR  <= 1'b0;
      end else begin
         state   <= state_d;
         window  <= window_d;
         cnt     <= cnt_d;
         sh_init <= sh_init_d;
         sh_inv  <= sh_inv_d;
         if (commit) begin
            INIT_Q   <= sh_init;
            INV_Q    <= sh_inv;
            CFG_DONE <= 1'b1;
            CFG_ERR  <= 1'b0;
         end else if (frame_bad) begin
            CFG_ERR <= 1'b1;
         end
      end
   end

   assign O = CFG_DONE & ((I1 ^ INV_Q[0]) | (I2 ^ INV_Q[1]));

`ifdef FASM_CFG_READBACK_EN
   localparam int RBW = INIT_WIDTH + 2;
   localparam int PW  = $clog2(RBW);

   logic [PW-1:0]  rb_ptr;
   logic [RBW-1:0] rb_vec;

   assign rb_vec = {INIT_Q, INV_Q} << rb_ptr;
   assign RB_DO  = RB_EN & rb_vec[RBW-1];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)                          rb_ptr <= '0;
      else if (!RB_EN || commit)        rb_ptr <= '0;
      else if (rb_ptr == PW'(RBW - 1))  rb_ptr <= '0;
      else                              rb_ptr <= rb_ptr + 1'b1;
   end
`endif

endmodule
